// File: rtl/pipelined_cla_adder_n_if.sv
// Handshake and data bundle for the pipelined CLA adder/subtractor.
// master drives operands and consumes results; slave is the adder itself.
interface pipelined_cla_adder_n_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, x, y, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, x, y, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_adder_n.sv
// Pipelined carry-lookahead adder/subtractor. WIDTH is cut into STAGES slices of
// STAGE_WIDTH bits; each stage sums one slice with a lookahead carry network and
// registers the carry for the next stage. The whole pipeline stalls together when
// the output holds a result that downstream is not accepting.
module pipelined_cla_adder_n #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned STAGE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_cla_adder_n_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / STAGE_WIDTH;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned SW     = STAGE_WIDTH;

  // Returns {carry_out, carry_into_msb, sum} for one slice. Every carry is a flat
  // sum of generate/propagate products rather than a chain through lower carries.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] a,
                                               input logic [SW-1:0] b,
                                               input logic          cin);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW:0]   c;
    logic          term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SW); i++) begin
      c[i+1] = g[i];
      term   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (term & g[j]);
        term   = term & p[j];
      end
      c[i+1] = c[i+1] | (term & cin);
    end
    return {c[SW], c[SW-1], p ^ c[SW-1:0]};
  endfunction

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] x_q     [STAGES];
  logic [WIDTH-1:0] x_d     [STAGES];
  logic [WIDTH-1:0] y_q     [STAGES];
  logic [WIDTH-1:0] y_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             stall;

  logic [WIDTH-1:0] xs, ys, ss;
  logic             cs, vs;
  logic [SW+1:0]    res;
  int unsigned      km1;

  // Next state of every stage: sum its slice, pass the still-unsummed operand bits on.
  always_comb begin
    stall      = valid_q[LAST] && !bus.out_ready;
    overflow_d = 1'b0;
    xs         = '0;
    ys         = '0;
    ss         = '0;
    cs         = 1'b0;
    vs         = 1'b0;
    res        = '0;
    km1        = 0;
    for (int k = 0; k < int'(STAGES); k++) begin
      km1 = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Subtraction is X + ~Y + ~borrow_in.
        xs = bus.x;
        ys = bus.sub ? ~bus.y : bus.y;
        cs = bus.carry_in ^ bus.sub;
        ss = '0;
        vs = bus.in_valid;
      end else begin
        xs = x_q[km1];
        ys = y_q[km1];
        cs = carry_q[km1];
        ss = sum_q[km1];
        vs = valid_q[km1];
      end
      res                       = cla_slice(xs[k*SW +: SW], ys[k*SW +: SW], cs);
      valid_d[k]                = vs;
      carry_d[k]                = res[SW+1];
      x_d[k]                    = xs;
      x_d[k][k*SW +: SW]        = '0;
      y_d[k]                    = ys;
      y_d[k][k*SW +: SW]        = '0;
      sum_d[k]                  = ss;
      sum_d[k][k*SW +: SW]      = res[SW-1:0];
      if (k == int'(LAST)) begin
        overflow_d = res[SW+1] ^ res[SW];
      end
    end
    zero_d = (sum_d[LAST] == '0);
  end

  // Pipeline registers; all stages advance together unless the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
        sum_q[k]   <= sum_d[k];
      end
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.carry_out = carry_q[LAST];
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
endmodule
